// File: rtl/lstm_seq_pkg.sv
// Shared state encoding, default sizing and address helper
// for the LSTM step sequencer.
package lstm_seq_pkg;

    typedef enum logic [1:0] {
        LOAD,
        FEED,
        WAIT,
        COMMIT
    } seq_state_t;

    localparam int DEF_X_SIZE = 10;
    localparam int DEF_H_SIZE = 16;
    localparam int INPUT_SIZE = DEF_X_SIZE + DEF_H_SIZE;
    localparam int AW         = $clog2(DEF_H_SIZE * INPUT_SIZE);

    function automatic int unsigned w_base(
        input int unsigned u,
        input int unsigned isz
    );
        return u * isz;
    endfunction

endpackage

// File: rtl/lstm_state_regs.sv
// Recurrent state storage: h double buffer, c buffer and the
// new-sequence read masking.
module lstm_state_regs
    import lstm_seq_pkg::*;
#(
    parameter int H_SIZE = DEF_H_SIZE,
    parameter int D_WL   = 16,
    parameter int UW     = 4
) (
    input  logic            clk,
    input  logic            i_zflag,
    input  logic [UW-1:0]   i_u,
    input  logic [UW-1:0]   i_hidx,
    input  logic            i_c_we,
    input  logic [D_WL-1:0] i_c,
    input  logic            i_h_we,
    input  logic [D_WL-1:0] i_h,
    input  logic            i_commit,
    output logic [D_WL-1:0] o_hprev,
    output logic [D_WL-1:0] o_cprev
);

    logic [D_WL-1:0] r_hprev [H_SIZE];
    logic [D_WL-1:0] r_hnew  [H_SIZE];
    logic [D_WL-1:0] r_cbuf  [H_SIZE];

    // hnew collects this frame's outputs so hprev stays stable
    // while later units still read it.
    always_ff @(posedge clk) begin
        if (i_c_we) r_cbuf[i_u] <= i_c;
        if (i_h_we) r_hnew[i_u] <= i_h;
        if (i_commit) r_hprev <= r_hnew;
    end

    assign o_hprev = i_zflag ? '0 : r_hprev[i_hidx];
    assign o_cprev = i_zflag ? '0 : r_cbuf[i_u];

endmodule

// File: rtl/lstm_step_sequencer.sv
// Frame loader, per-unit operand streamer and state capture
// in front of the time-multiplexed LSTM cell.
module lstm_step_sequencer
    import lstm_seq_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int H_SIZE = DEF_H_SIZE,
    parameter int D_WL   = 16,
    localparam int ISZ   = X_SIZE + H_SIZE,
    localparam int AWL   = $clog2(H_SIZE * ISZ),
    localparam int UW    = (H_SIZE > 1) ? $clog2(H_SIZE) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [D_WL-1:0] s_data,
    input  logic            s_first,
    output logic [AWL-1:0]  w_addr,
    output logic [UW-1:0]   b_addr,
    output logic [D_WL-1:0] cell_x,
    output logic            cell_in_valid,
    output logic [D_WL-1:0] pre_c,
    input  logic            c_o_valid,
    input  logic [D_WL-1:0] c_o,
    input  logic            h_o_valid,
    input  logic [D_WL-1:0] h_o,
    output logic            o_valid,
    output logic [D_WL-1:0] o_data,
    output logic            o_last,
    output logic            frame_done,
    output logic            err
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int JW = $clog2(ISZ);
    localparam logic [XW-1:0] K_LAST = XW'(X_SIZE - 1);
    localparam logic [JW-1:0] J_LAST = JW'(ISZ - 1);
    localparam logic [JW-1:0] J_X    = JW'(X_SIZE);
    localparam logic [UW-1:0] U_LAST = UW'(H_SIZE - 1);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [XW-1:0]   r_k;
    logic [JW-1:0]   r_j;
    logic [UW-1:0]   r_u;
    logic            r_zflag;
    logic            r_c_seen;
    logic            r_err;
    logic            r_civ;
    logic [D_WL-1:0] r_cell_x;
    logic [D_WL-1:0] r_xbuf [X_SIZE];

    logic            w_hs;
    logic            w_c_we;
    logic            w_h_we;
    logic            w_commit;
    logic            w_err_set;
    logic            w_busy;
    logic [UW-1:0]   w_hidx;
    logic [D_WL-1:0] w_hprev;
    logic [D_WL-1:0] w_cprev;
    logic [D_WL-1:0] w_elem;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        s_ready    = 1'b0;
        w_hs       = 1'b0;
        w_addr     = '0;
        w_c_we     = 1'b0;
        w_h_we     = 1'b0;
        w_commit   = 1'b0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_last     = 1'b0;
        frame_done = 1'b0;
        unique case (r_state)
            LOAD: begin
                s_ready = 1'b1;
                w_hs    = s_valid;
                if (s_valid && r_k == K_LAST) w_next = FEED;
            end
            FEED: begin
                w_addr = AWL'(w_base(32'(r_u), ISZ)) + AWL'(r_j);
                if (r_j == J_LAST) w_next = WAIT;
            end
            WAIT: begin
                w_c_we = c_o_valid;
                if (h_o_valid) begin
                    w_h_we  = 1'b1;
                    o_valid = 1'b1;
                    o_data  = h_o;
                    o_last  = (r_u == U_LAST);
                    w_next  = (r_u == U_LAST) ? COMMIT : FEED;
                end
            end
            COMMIT: begin
                frame_done = 1'b1;
                w_commit   = 1'b1;
                w_next     = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    // Cell results outside WAIT, or h without its c, are protocol errors.
    assign w_err_set = (r_state != WAIT) ? (c_o_valid | h_o_valid)
                     : (h_o_valid & ~c_o_valid & ~r_c_seen);

    assign w_hidx = (r_j >= J_X) ? UW'(r_j - J_X) : '0;
    assign w_elem = (r_j < J_X) ? r_xbuf[XW'(r_j)] : w_hprev;
    assign w_busy = (r_state == FEED) || (r_state == WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_j      <= '0;
            r_u      <= '0;
            r_zflag  <= 1'b0;
            r_c_seen <= 1'b0;
            r_err    <= 1'b0;
            r_civ    <= 1'b0;
            r_cell_x <= '0;
        end else begin
            r_civ    <= (r_state == FEED);
            r_cell_x <= (r_state == FEED) ? w_elem : '0;
            if (w_err_set) r_err <= 1'b1;
            if (w_hs) begin
                r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                if (r_k == '0) r_zflag <= s_first;
            end
            if (r_state == FEED) begin
                r_j      <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
                r_c_seen <= 1'b0;
            end
            if (w_c_we) r_c_seen <= 1'b1;
            if (w_h_we && r_u != U_LAST) r_u <= r_u + 1'b1;
            if (w_commit) begin
                r_u     <= '0;
                r_zflag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) r_xbuf[r_k] <= s_data;
    end

    lstm_state_regs #(
        .H_SIZE (H_SIZE),
        .D_WL   (D_WL),
        .UW     (UW)
    ) u_state (
        .clk      (clk),
        .i_zflag  (r_zflag),
        .i_u      (r_u),
        .i_hidx   (w_hidx),
        .i_c_we   (w_c_we),
        .i_c      (c_o),
        .i_h_we   (w_h_we),
        .i_h      (h_o),
        .i_commit (w_commit),
        .o_hprev  (w_hprev),
        .o_cprev  (w_cprev)
    );

    assign b_addr        = r_u;
    assign pre_c         = w_busy ? w_cprev : '0;
    assign cell_x        = r_cell_x;
    assign cell_in_valid = r_civ;
    assign err           = r_err;

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Self-checking bench: random frames against a frame-level
// reference of the sequencer plus a fixed-latency cell model.
module tb_lstm_step_sequencer;

    localparam int XS  = 2;
    localparam int HS  = 2;
    localparam int DW  = 16;
    localparam int IN  = XS + HS;
    localparam int LAT = 5;
    localparam int AWB = $clog2(HS * IN);
    localparam int UWB = $clog2(HS);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           s_first = 1'b0;
    logic [AWB-1:0] w_addr;
    logic [UWB-1:0] b_addr;
    logic [DW-1:0]  cell_x;
    logic           cell_in_valid;
    logic [DW-1:0]  pre_c;
    logic           c_o_valid = 1'b0;
    logic [DW-1:0]  c_o = '0;
    logic           h_o_valid = 1'b0;
    logic [DW-1:0]  h_o = '0;
    logic           o_valid;
    logic [DW-1:0]  o_data;
    logic           o_last;
    logic           frame_done;
    logic           err;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] cur_x [XS];
    logic [DW-1:0] cur_c [HS];
    logic [DW-1:0] cur_h [HS];
    logic [DW-1:0] mh [HS];
    logic [DW-1:0] mc [HS];
    bit            cur_first;
    logic          exp_err;

    always #5 clk = ~clk;

    lstm_step_sequencer #(
        .X_SIZE (XS),
        .H_SIZE (HS),
        .D_WL   (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_first       (s_first),
        .w_addr        (w_addr),
        .b_addr        (b_addr),
        .cell_x        (cell_x),
        .cell_in_valid (cell_in_valid),
        .pre_c         (pre_c),
        .c_o_valid     (c_o_valid),
        .c_o           (c_o),
        .h_o_valid     (h_o_valid),
        .h_o           (h_o),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .frame_done    (frame_done),
        .err           (err)
    );

    function automatic logic [DW-1:0] exp_x(input int j);
        if (j < XS) return cur_x[j];
        return cur_first ? '0 : mh[j - XS];
    endfunction

    function automatic logic [DW-1:0] exp_prec(input int u);
        return cur_first ? '0 : mc[u];
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk_in(input bit stress);
        s_valid   = stress ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data    = DW'($urandom);
        s_first   = 1'($urandom_range(0, 1));
        c_o_valid = 1'b0;
        h_o_valid = 1'b0;
        c_o       = DW'($urandom);
        h_o       = DW'($urandom);
    endtask

    task automatic apply_reset(input int n);
        junk_in(0);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
        exp_err = 1'b0;
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < XS; i++) cur_x[i] = DW'($urandom);
        for (int i = 0; i < HS; i++) begin
            cur_c[i] = DW'($urandom);
            cur_h[i] = DW'($urandom);
        end
    endtask

    // One full frame: load, stream every unit, answer as the cell, commit.
    task automatic run_frame(input bit first, input bit stress,
                             input int skip_c, input int abort_j);
        int k;
        int guard;
        int cmode;
        bit ok;
        bit c_done;
        k = 0;
        guard = 0;
        cur_first = first;
        while (k < XS && guard < 200) begin
            junk_in(stress);
            if (!stress) s_valid = 1'b1;
            if (s_valid) s_data = cur_x[k];
            if (k == 0) s_first = first;
            #1;
            checks++;
            if (s_ready !== 1'b1 || frame_done !== 1'b0 || cell_in_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_ctl k=%0d got rdy=%b fd=%b civ=%b exp 1 0 0",
                         k, s_ready, frame_done, cell_in_valid);
            end
            if (s_valid) k++;
            guard++;
            step();
        end
        if (k < XS) begin
            failures++;
            $display("FAIL load_timeout got accepted=%0d exp %0d", k, XS);
        end
        for (int u = 0; u < HS; u++) begin
            cmode = stress ? int'($urandom_range(0, 1)) : 0;
            c_done = 1'b0;
            for (int j = 0; j < IN; j++) begin
                junk_in(stress);
                #1;
                checks++;
                if (w_addr !== AWB'(u * IN + j) || b_addr !== UWB'(u) || s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL feed_addr u=%0d j=%0d got w=%0d b=%0d rdy=%b exp w=%0d b=%0d rdy=0",
                             u, j, w_addr, b_addr, s_ready, u * IN + j, u);
                end
                checks++;
                if (pre_c !== exp_prec(u)) begin
                    failures++;
                    $display("FAIL feed_prec u=%0d j=%0d got %h exp %h", u, j, pre_c, exp_prec(u));
                end
                checks++;
                if (j == 0) ok = (cell_in_valid === 1'b0);
                else ok = (cell_in_valid === 1'b1) && (cell_x === exp_x(j - 1));
                if (!ok) begin
                    failures++;
                    $display("FAIL feed_x u=%0d j=%0d got civ=%b x=%h exp civ=%0d x=%h",
                             u, j, cell_in_valid, cell_x, j != 0, (j == 0) ? '0 : exp_x(j - 1));
                end
                if (u == 0 && j == abort_j) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                    return;
                end
                step();
            end
            for (int w = 0; w <= LAT; w++) begin
                bit c_now;
                bit lack_c;
                junk_in(stress);
                c_now = (skip_c != u) && (w == ((cmode != 0) ? LAT : LAT - 1));
                c_o_valid = c_now;
                if (c_now) c_o = cur_c[u];
                h_o_valid = (w == LAT);
                if (w == LAT) h_o = cur_h[u];
                lack_c = (w == LAT) && !c_done && !c_now;
                #1;
                checks++;
                if (w == 0) ok = (cell_in_valid === 1'b1) && (cell_x === exp_x(IN - 1));
                else ok = (cell_in_valid === 1'b0);
                if (!ok) begin
                    failures++;
                    $display("FAIL wait_x u=%0d w=%0d got civ=%b x=%h exp civ=%0d x=%h",
                             u, w, cell_in_valid, cell_x, w == 0, exp_x(IN - 1));
                end
                checks++;
                if (o_valid !== (w == LAT)) begin
                    failures++;
                    $display("FAIL out_valid u=%0d w=%0d got %b exp %0d", u, w, o_valid, w == LAT);
                end
                if (w == LAT) begin
                    checks++;
                    if (o_data !== cur_h[u] || o_last !== (u == HS - 1)) begin
                        failures++;
                        $display("FAIL out_data u=%0d got %h last=%b exp %h last=%0d",
                                 u, o_data, o_last, cur_h[u], u == HS - 1);
                    end
                end
                checks++;
                if (s_ready !== 1'b0 || frame_done !== 1'b0 || b_addr !== UWB'(u) || err !== exp_err) begin
                    failures++;
                    $display("FAIL wait_ctl u=%0d w=%0d got rdy=%b fd=%b b=%0d err=%b exp 0 0 %0d %b",
                             u, w, s_ready, frame_done, b_addr, err, u, exp_err);
                end
                if (w < LAT - 1) begin
                    checks++;
                    if (pre_c !== exp_prec(u)) begin
                        failures++;
                        $display("FAIL wait_prec u=%0d w=%0d got %h exp %h", u, w, pre_c, exp_prec(u));
                    end
                end
                step();
                if (c_now) begin
                    c_done = 1'b1;
                    mc[u] = cur_c[u];
                end
                if (lack_c) exp_err = 1'b1;
            end
        end
        junk_in(stress);
        #1;
        checks++;
        if (frame_done !== 1'b1 || s_ready !== 1'b0 || o_valid !== 1'b0 || err !== exp_err) begin
            failures++;
            $display("FAIL commit got fd=%b rdy=%b ov=%b err=%b exp 1 0 0 %b",
                     frame_done, s_ready, o_valid, err, exp_err);
        end
        step();
        for (int i = 0; i < HS; i++) mh[i] = cur_h[i];
    endtask

    task automatic test_reset();
        apply_reset(2);
        #1;
        checks++;
        if (s_ready !== 1'b1 || cell_in_valid !== 1'b0 || cell_x !== '0 || w_addr !== '0 ||
            b_addr !== '0 || pre_c !== '0 || o_valid !== 1'b0 || o_last !== 1'b0 ||
            frame_done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got rdy=%b civ=%b x=%h wa=%0d ba=%0d pc=%h ov=%b ol=%b fd=%b err=%b",
                     s_ready, cell_in_valid, cell_x, w_addr, b_addr, pre_c, o_valid, o_last,
                     frame_done, err);
        end
    endtask

    task automatic test_address_stream();
        cur_x[0] = 16'h1000;
        cur_x[1] = 16'h0800;
        cur_c[0] = 16'h0400;
        cur_c[1] = 16'h0500;
        cur_h[0] = 16'h0200;
        cur_h[1] = 16'h0300;
        run_frame(1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_state_capture();
        randomize_frame();
        run_frame(1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_first_clears();
        randomize_frame();
        run_frame(1'b1, 1'b0, -1, -1);
        randomize_frame();
        run_frame(1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_handshake_stress();
        for (int f = 0; f < 6; f++) begin
            randomize_frame();
            run_frame(f == 3, 1'b1, -1, -1);
        end
    endtask

    task automatic test_protocol_err();
        apply_reset(1);
        h_o_valid = 1'b1;
        h_o = 16'h7777;
        #1;
        checks++;
        if (o_valid !== 1'b0 || s_ready !== 1'b1 || cell_in_valid !== 1'b0 || w_addr !== '0) begin
            failures++;
            $display("FAIL stray_h_out got ov=%b rdy=%b civ=%b wa=%0d exp 0 1 0 0",
                     o_valid, s_ready, cell_in_valid, w_addr);
        end
        step();
        h_o_valid = 1'b0;
        exp_err = 1'b1;
        #1;
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_h_err got err=%b rdy=%b exp 1 1", err, s_ready);
        end
        randomize_frame();
        run_frame(1'b1, 1'b0, -1, -1);
        apply_reset(1);
        randomize_frame();
        run_frame(1'b1, 1'b0, 0, -1);
        checks++;
        if (exp_err !== 1'b1) begin
            failures++;
            $display("FAIL missing_c_model got %b exp 1", exp_err);
        end
        randomize_frame();
        run_frame(1'b0, 1'b1, -1, -1);
    endtask

    task automatic test_reset_mid_feed();
        randomize_frame();
        run_frame(1'b0, 1'b0, -1, 2);
        exp_err = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || cell_in_valid !== 1'b0 || cell_x !== '0 || w_addr !== '0 ||
            b_addr !== '0 || pre_c !== '0 || o_valid !== 1'b0 || o_last !== 1'b0 ||
            frame_done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midfeed_reset got rdy=%b civ=%b x=%h wa=%0d ba=%0d pc=%h ov=%b ol=%b fd=%b err=%b",
                     s_ready, cell_in_valid, cell_x, w_addr, b_addr, pre_c, o_valid, o_last,
                     frame_done, err);
        end
        test_address_stream();
        test_state_capture();
    endtask

    initial begin
        exp_err = 1'b0;
        cur_first = 1'b1;
        for (int i = 0; i < HS; i++) begin
            mh[i] = '0;
            mc[i] = '0;
        end
        test_reset();
        test_address_stream();
        test_state_capture();
        test_first_clears();
        test_handshake_stress();
        test_protocol_err();
        test_reset_mid_feed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
